vga_scan_gen: RTL and testbench

- Raster timing source and pixel output stage for the 640x480@60 VGA display.
- Drives h_cnt/v_cnt/valid to the sprite pixel generator and receives its 12-bit Pixel after the block-RAM read latency.
- Produces aligned hsync/vsync/RGB to the connector, plus frame_start and frame_cnt for game-logic and animation pacing.

---
 rtl/vga_scan_gen.sv | 112 +++++++++++
 tb/tb_vga_scan_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster counters, sync generation and pixel output stage.
// Syncs and blanking are delayed to line up with pixel_in from the pixel generator.
module vga_scan_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIXEL_LAT = 1
) (
  input  logic        clk_25Hz,
  input  logic        rst,
  input  logic [11:0] pixel_in,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        valid,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        fs_q, fs_d;
  logic        line_end, frame_end;
  logic        hs_raw, vs_raw;

  logic [PIXEL_LAT-1:0] vld_dly_q;
  logic [PIXEL_LAT-1:0] hs_dly_q;
  logic [PIXEL_LAT-1:0] vs_dly_q;

  logic        hs_q, vs_q;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    line_end  = (h_q == H_LAST);
    frame_end = line_end && (v_q == V_LAST);
    h_d       = line_end ? 10'd0 : h_q + 10'd1;
    v_d       = v_q;
    if (line_end)
      v_d = frame_end ? 10'd0 : v_q + 10'd1;
    fcnt_d    = frame_end ? fcnt_q + 16'd1 : fcnt_q;
    fs_d      = frame_end;
    hs_raw    = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_raw    = !((v_q >= VS_BEG) && (v_q < VS_END));
    rgb_d     = vld_dly_q[PIXEL_LAT-1] ? pixel_in : 12'h000;
  end

  assign valid = (h_q < H_ACT) && (v_q < V_ACT);

  always_ff @(posedge clk_25Hz) begin
    if (!rst) begin
      h_q       <= '0;
      v_q       <= '0;
      fcnt_q    <= '0;
      fs_q      <= 1'b0;
      vld_dly_q <= '0;
      hs_dly_q  <= '1;
      vs_dly_q  <= '1;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rgb_q     <= '0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      fcnt_q       <= fcnt_d;
      fs_q         <= fs_d;
      vld_dly_q[0] <= valid;
      hs_dly_q[0]  <= hs_raw;
      vs_dly_q[0]  <= vs_raw;
      for (int i = 1; i < PIXEL_LAT; i++) begin
        vld_dly_q[i] <= vld_dly_q[i-1];
        hs_dly_q[i]  <= hs_dly_q[i-1];
        vs_dly_q[i]  <= vs_dly_q[i-1];
      end
      hs_q  <= hs_dly_q[PIXEL_LAT-1];
      vs_q  <= vs_dly_q[PIXEL_LAT-1];
      rgb_q <= rgb_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign vgaRed      = rgb_q[11:8];
  assign vgaGreen    = rgb_q[7:4];
  assign vgaBlue     = rgb_q[3:0];
  assign frame_start = fs_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: scaled raster, two pixel latencies, scoreboard vs.
// a cycle-count reference model plus tables and hand sequences.
module tb_vga_scan_gen;

  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] pixel_in = 12'h000;

  logic [9:0]  h1, v1, h3, v3;
  logic        val1, val3, hs1, hs3, vs1, vs3, fs1, fs3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;
  logic [15:0] fc1, fc3;

  int vectors = 0;
  int miscompares = 0;

  logic bram = 1'b0;
  logic rnd  = 1'b1;

  always #20 clk = ~clk;

  vga_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIXEL_LAT(1)
  ) u_l1 (
    .clk_25Hz(clk), .rst(rst), .pixel_in(pixel_in),
    .h_cnt(h1), .v_cnt(v1), .valid(val1),
    .hsync(hs1), .vsync(vs1),
    .vgaRed(r1), .vgaGreen(g1), .vgaBlue(b1),
    .frame_start(fs1), .frame_cnt(fc1)
  );

  vga_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIXEL_LAT(3)
  ) u_l3 (
    .clk_25Hz(clk), .rst(rst), .pixel_in(pixel_in),
    .h_cnt(h3), .v_cnt(v3), .valid(val3),
    .hsync(hs3), .vsync(vs3),
    .vgaRed(r3), .vgaGreen(g3), .vgaBlue(b3),
    .frame_start(fs3), .frame_cnt(fc3)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from edges counted since reset.
  longint      n = 0;
  logic        armed = 1'b0;
  logic [11:0] pix_s = 12'h000;

  always @(posedge clk) begin
    pix_s <= pixel_in;
    if (!rst) begin
      n     <= 0;
      armed <= 1'b1;
    end else begin
      n <= n + 1;
    end
  end

  function automatic bit vis(input longint j);
    return ((j % HT) < HA) && (((j / HT) % VT) < VA);
  endfunction

  function automatic bit hs_at(input longint j);
    longint h;
    h = j % HT;
    return !((h >= HA + HF) && (h < HA + HF + HS));
  endfunction

  function automatic bit vs_at(input longint j);
    longint v;
    v = (j / HT) % VT;
    return !((v >= VA + VF) && (v < VA + VF + VS));
  endfunction

  task automatic mchk(input int lat, input logic [9:0] h, input logic [9:0] v,
                      input logic vd, input logic hs, input logic vs,
                      input logic fs, input logic [11:0] rgb,
                      input logic [15:0] fc);
    longint      j;
    logic [11:0] er;
    logic        ehs, evs;
    j   = n - longint'(lat) - 1;
    er  = (j >= 0 && vis(j)) ? pix_s : 12'h000;
    ehs = (j >= 0) ? hs_at(j) : 1'b1;
    evs = (j >= 0) ? vs_at(j) : 1'b1;
    chk($sformatf("L%0d h_cnt", lat), 32'(h), 32'(n % HT));
    chk($sformatf("L%0d v_cnt", lat), 32'(v), 32'((n / HT) % VT));
    chk($sformatf("L%0d valid", lat), 32'(vd), 32'(vis(n)));
    chk($sformatf("L%0d hsync", lat), 32'(hs), 32'(ehs));
    chk($sformatf("L%0d vsync", lat), 32'(vs), 32'(evs));
    chk($sformatf("L%0d rgb", lat), 32'(rgb), 32'(er));
    chk($sformatf("L%0d frame_start", lat), 32'(fs),
        32'(n > 0 && (n % FT) == 0));
    chk($sformatf("L%0d frame_cnt", lat), 32'(fc), 32'((n / FT) % 65536));
  endtask

  always @(negedge clk) begin
    if (armed) begin
      mchk(1, h1, v1, val1, hs1, vs1, fs1, {r1, g1, b1}, fc1);
      mchk(3, h3, v3, val3, hs3, vs3, fs3, {r3, g3, b3}, fc3);
    end
  end

  // One clock; pixel_in plays a 1-clk BRAM fed by h_cnt when bram is set.
  task automatic tick();
    logic [9:0] hp;
    hp = h1;
    @(posedge clk);
    #1;
    if (bram)
      pixel_in = {2'b00, hp};
    else if (rnd)
      pixel_in = 12'($urandom);
  endtask

  function automatic logic pick(input int s);
    case (s)
      0: return hs1;
      1: return vs1;
      2: return hs3;
      default: return vs3;
    endcase
  endfunction

  task automatic measure(input int s, output int low, output int per,
                         output logic [9:0] hf, output logic [9:0] vf);
    int k;
    k = 0;
    while (pick(s) !== 1'b1 && k < 2 * FT) begin tick(); k++; end
    while (pick(s) !== 1'b0 && k < 4 * FT) begin tick(); k++; end
    hf  = h1;
    vf  = v1;
    low = 0;
    while (pick(s) === 1'b0 && low < 2 * FT) begin tick(); low++; end
    per = low;
    while (pick(s) === 1'b1 && per < 2 * FT) begin tick(); per++; end
  endtask

  task automatic wait_hv(input int h, input int v);
    int k;
    k = 0;
    while (!(h1 == 10'(h) && v1 == 10'(v)) && k < 2 * FT) begin
      tick();
      k++;
    end
    chk($sformatf("reach h=%0d v=%0d", h, v), 32'(k < 2 * FT), 32'd1);
  endtask

  typedef struct {
    int          h;
    int          v;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } vec_t;

  vec_t tbl[$];

  int low, per, k, c1, c3;
  logic [9:0] hf, vf;
  int e_low[4];
  int e_per[4];
  int e_hf[4];

  initial begin
    tbl.push_back('{5,  0, 12'h005, 1'b1, 1'b1});
    tbl.push_back('{39, 0, 12'h027, 1'b1, 1'b1});
    tbl.push_back('{40, 0, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{43, 0, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{44, 0, 12'h000, 1'b0, 1'b1});
    tbl.push_back('{51, 0, 12'h000, 1'b0, 1'b1});
    tbl.push_back('{52, 0, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{5,  9, 12'h005, 1'b1, 1'b1});
    tbl.push_back('{5, 10, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{0, 11, 12'h000, 1'b1, 1'b1});
    tbl.push_back('{0, 12, 12'h000, 1'b1, 1'b0});
    tbl.push_back('{57, 13, 12'h000, 1'b1, 1'b0});
    tbl.push_back('{0, 14, 12'h000, 1'b1, 1'b1});
    e_low = '{HS, VS * HT, HS, VS * HT};
    e_per = '{HT, FT, HT, FT};
    e_hf  = '{HA + HF + 2, 2, HA + HF + 4, 4};

    // Reset held for 5 clocks
    rst = 1'b0;
    repeat (5) tick();
    chk("rst h_cnt", 32'(h1), 32'd0);
    chk("rst v_cnt", 32'(v1), 32'd0);
    chk("rst hsync", 32'(hs1), 32'd1);
    chk("rst vsync", 32'(vs1), 32'd1);
    chk("rst rgb", 32'({r1, g1, b1}), 32'd0);
    chk("rst frame_cnt", 32'(fc1), 32'd0);
    chk("rst frame_start", 32'(fs1), 32'd0);
    rst = 1'b1;

    // First and second frame_start pulses
    for (int f = 1; f <= 2; f++) begin
      k = 0;
      do begin tick(); k++; end while (fs1 !== 1'b1 && k < FT + 10);
      chk($sformatf("frame_start period %0d", f), 32'(k), 32'(FT));
      chk($sformatf("frame_cnt at pulse %0d", f), 32'(fc1), 32'(f));
    end

    // Sync widths, periods and alignment for both latencies
    for (int s = 0; s < 4; s++) begin
      measure(s, low, per, hf, vf);
      chk($sformatf("sync%0d low width", s), 32'(low), 32'(e_low[s]));
      chk($sformatf("sync%0d period", s), 32'(per), 32'(e_per[s]));
      chk($sformatf("sync%0d fall h", s), 32'(hf), 32'(e_hf[s]));
      if (s % 2 == 1)
        chk($sformatf("sync%0d fall v", s), 32'(vf), 32'(VA + VF));
    end

    // Pixel alignment and sync edges with a 1-clk BRAM
    bram = 1'b1;
    tick();
    foreach (tbl[i]) begin
      wait_hv(tbl[i].h, tbl[i].v);
      tick();
      tick();
      chk($sformatf("tbl%0d rgb", i), 32'({r1, g1, b1}), 32'(tbl[i].rgb));
      chk($sformatf("tbl%0d hsync", i), 32'(hs1), 32'(tbl[i].hs));
      chk($sformatf("tbl%0d vsync", i), 32'(vs1), 32'(tbl[i].vs));
    end
    bram = 1'b0;

    // Blanking with a constant white source
    rnd = 1'b0;
    pixel_in = 12'hFFF;
    wait_hv(0, 0);
    c1 = 0;
    c3 = 0;
    for (int i = 0; i < FT; i++) begin
      tick();
      if ({r1, g1, b1} == 12'hFFF) c1++;
      if ({r3, g3, b3} == 12'hFFF) c3++;
    end
    chk("white count L1", 32'(c1), 32'(HA * VA));
    chk("white count L3", 32'(c3), 32'(HA * VA));
    rnd = 1'b1;

    // Mid-frame single-clock resets, inside and outside the hsync pulse
    for (int p = 0; p < 2; p++) begin
      wait_hv(p == 0 ? HA + HF + 2 : 30, 5);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid rst h_cnt", 32'(h1), 32'd0);
      chk("mid rst v_cnt", 32'(v1), 32'd0);
      chk("mid rst frame_cnt", 32'(fc1), 32'd0);
      for (int c = 0; c < 2; c++) begin
        chk("mid rst hsync", 32'(hs1), 32'd1);
        chk("mid rst vsync", 32'(vs1), 32'd1);
        chk("mid rst hsync L3", 32'(hs3), 32'd1);
        chk("mid rst rgb", 32'({r1, g1, b1}), 32'd0);
        chk("mid rst frame_start", 32'(fs1), 32'd0);
        tick();
      end
    end

    // Random pixels with occasional short resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
